// File: rtl/time_pkg.sv
// Shared time-of-day types and BCD helpers for the clock datapath,
// the alarm comparator and the display multiplexer.
package time_pkg;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  typedef struct packed {
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
  } bcd_time;

  // Two-digit BCD successor; the wrap test uses the whole byte so 19 -> 20 still carries.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] max);
    logic [7:0] result;
    if (value == max) begin
      result = 8'h00;
    end else if (value[3:0] == 4'h9) begin
      result = {value[7:4] + 4'h1, 4'h0};
    end else begin
      result = {value[7:4], value[3:0] + 4'h1};
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps at MAX back to 00; clr has priority over inc.
// carry flags the increment that wraps, for chaining into the next field.
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rst_value,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] value_r;

  // Field register: reset value, clear, or BCD step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= rst_value;
    end else if (clr) begin
      value_r <= 8'h00;
    end else if (inc) begin
      value_r <= bcd_inc(value_r, MAX);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;
  assign carry = inc & (value_r == MAX);

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD wall clock advanced by rising edges of the divider output,
// with a set mode in which hours and minutes are stepped by button pulses.
module time_keeper
  import time_pkg::*;
#(
  parameter logic [7:0] RST_HOUR = 8'h00,
  parameter logic [7:0] RST_MIN  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       sec_pulse,
  output logic       day_wrap
);

  logic       tick_q_r;
  logic       sec_pulse_r;
  logic       day_wrap_r;
  logic       rise_s;
  logic       sec_inc_s;
  logic       min_inc_s;
  logic       hour_inc_s;
  logic       sec_carry_s;
  logic       min_carry_s;
  logic       hour_carry_s;
  logic [7:0] sec_val_s;
  logic [7:0] min_val_s;
  logic [7:0] hour_val_s;
  bcd_time    now_s;

  // Edge-detect register for the divider square wave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q_r <= 1'b0;
    end else begin
      tick_q_r <= tick_in;
    end
  end

  assign rise_s = tick_in & ~tick_q_r;

  // Set mode swaps the carry chain for the buttons; a tick arriving then is dropped.
  assign sec_inc_s  = rise_s & ~set_mode;
  assign min_inc_s  = set_mode ? inc_min  : sec_carry_s;
  assign hour_inc_s = set_mode ? inc_hour : min_carry_s;

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk       (clk),
    .rst       (rst),
    .rst_value (8'h00),
    .inc       (sec_inc_s),
    .clr       (set_mode),
    .value     (sec_val_s),
    .carry     (sec_carry_s)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk       (clk),
    .rst       (rst),
    .rst_value (RST_MIN),
    .inc       (min_inc_s),
    .clr       (1'b0),
    .value     (min_val_s),
    .carry     (min_carry_s)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk       (clk),
    .rst       (rst),
    .rst_value (RST_HOUR),
    .inc       (hour_inc_s),
    .clr       (1'b0),
    .value     (hour_val_s),
    .carry     (hour_carry_s)
  );

  // Strobes registered so they line up with the freshly updated fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_pulse_r <= 1'b0;
      day_wrap_r  <= 1'b0;
    end else begin
      sec_pulse_r <= sec_inc_s;
      day_wrap_r  <= hour_carry_s & ~set_mode;
    end
  end

  assign now_s     = '{hours: hour_val_s, minutes: min_val_s, seconds: sec_val_s};
  assign hours     = now_s.hours;
  assign minutes   = now_s.minutes;
  assign seconds   = now_s.seconds;
  assign sec_pulse = sec_pulse_r;
  assign day_wrap  = day_wrap_r;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: a seconds-of-day model checked every cycle,
// plus literal time expectations at the scenario milestones.
module tb_time_keeper;

  localparam int RST_H_BIN = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic       set_mode = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       sec_pulse;
  logic       day_wrap;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  int m_sod;
  bit m_tq;
  bit m_pulse;
  bit m_wrap;

  time_keeper #(.RST_HOUR(8'h07), .RST_MIN(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .set_mode  (set_mode),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds),
    .sec_pulse (sec_pulse),
    .day_wrap  (day_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Time of day as a single seconds counter; set-mode steps edit the h/m digits directly.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sod   <= RST_H_BIN * 3600;
      m_tq    <= 1'b0;
      m_pulse <= 1'b0;
      m_wrap  <= 1'b0;
    end else begin
      m_tq <= tick_in;
      if (set_mode) begin
        m_sod <= (inc_hour ? (m_sod / 3600 + 1) % 24 : m_sod / 3600) * 3600
               + (inc_min ? ((m_sod / 60) % 60 + 1) % 60 : (m_sod / 60) % 60) * 60;
        m_pulse <= 1'b0;
        m_wrap  <= 1'b0;
      end else if (tick_in && !m_tq) begin
        m_sod   <= (m_sod + 1) % 86400;
        m_pulse <= 1'b1;
        m_wrap  <= (m_sod == 86399);
      end else begin
        m_pulse <= 1'b0;
        m_wrap  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_hours",   hours,   to_bcd(m_sod / 3600));
      chk("model_minutes", minutes, to_bcd((m_sod / 60) % 60));
      chk("model_seconds", seconds, to_bcd(m_sod % 60));
      chk("model_sec_pulse", {7'd0, sec_pulse}, {7'd0, m_pulse});
      chk("model_day_wrap",  {7'd0, day_wrap},  {7'd0, m_wrap});
    end
  end

  task automatic expect_time(input string name, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s);
    chk({name, "_h"}, hours, h);
    chk({name, "_m"}, minutes, m);
    chk({name, "_s"}, seconds, s);
    chk({name, "_model_h"}, to_bcd(m_sod / 3600), h);
    chk({name, "_model_m"}, to_bcd((m_sod / 60) % 60), m);
    chk({name, "_model_s"}, to_bcd(m_sod % 60), s);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input bit m, input bit h, input int n, input bit tog);
    repeat (n) begin
      inc_min  = m;
      inc_hour = h;
      if (tog) tick_in = 1'b1;
      @(negedge clk);
      inc_min  = 1'b0;
      inc_hour = 1'b0;
      tick_in  = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    check_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    expect_time("reset", 8'h07, 8'h00, 8'h00);
    chk("reset_sec_pulse", {7'd0, sec_pulse}, 8'h00);

    // 1: three rises, strobe one clk after the sampling edge
    for (int i = 1; i <= 3; i++) begin
      tick_in = 1'b1;
      @(negedge clk);
      chk("t1_pulse_on", {7'd0, sec_pulse}, 8'h01);
      chk("t1_seconds", seconds, to_bcd(i));
      tick_in = 1'b0;
      @(negedge clk);
      chk("t1_pulse_off", {7'd0, sec_pulse}, 8'h00);
    end
    expect_time("t1_end", 8'h07, 8'h00, 8'h03);

    // 2: seconds carry and minute carry into hours
    set_mode = 1'b1;
    cyc(1);
    pulse(1'b0, 1'b1, 17, 1'b0);
    expect_time("t2_set", 8'h00, 8'h00, 8'h00);
    set_mode = 1'b0;
    cyc(1);
    tick(59);
    expect_time("t2_a_pre", 8'h00, 8'h00, 8'h59);
    tick(1);
    expect_time("t2_a_post", 8'h00, 8'h01, 8'h00);
    set_mode = 1'b1;
    pulse(1'b1, 1'b0, 58, 1'b0);
    set_mode = 1'b0;
    cyc(1);
    tick(59);
    expect_time("t2_b_pre", 8'h00, 8'h59, 8'h59);
    tick(1);
    expect_time("t2_b_post", 8'h01, 8'h00, 8'h00);

    // 3: midnight rollover
    set_mode = 1'b1;
    pulse(1'b0, 1'b1, 22, 1'b0);
    pulse(1'b1, 1'b0, 59, 1'b0);
    set_mode = 1'b0;
    cyc(1);
    tick(59);
    expect_time("t3_pre", 8'h23, 8'h59, 8'h59);
    tick_in = 1'b1;
    @(negedge clk);
    expect_time("t3_post", 8'h00, 8'h00, 8'h00);
    chk("t3_day_wrap_on", {7'd0, day_wrap}, 8'h01);
    chk("t3_sec_pulse_on", {7'd0, sec_pulse}, 8'h01);
    tick_in = 1'b0;
    @(negedge clk);
    chk("t3_day_wrap_off", {7'd0, day_wrap}, 8'h00);

    // 4: set mode steps with ticks toggling
    set_mode = 1'b1;
    pulse(1'b0, 1'b1, 9, 1'b1);
    pulse(1'b1, 1'b0, 59, 1'b1);
    expect_time("t4_start", 8'h09, 8'h59, 8'h00);
    pulse(1'b1, 1'b0, 1, 1'b1);
    expect_time("t4_min_wrap", 8'h09, 8'h00, 8'h00);
    pulse(1'b0, 1'b1, 15, 1'b1);
    expect_time("t4_hour_wrap", 8'h00, 8'h00, 8'h00);
    pulse(1'b1, 1'b1, 1, 1'b1);
    expect_time("t4_both", 8'h01, 8'h01, 8'h00);

    // 5: buttons ignored in run mode, count resumes from :00
    pulse(1'b0, 1'b1, 11, 1'b0);
    pulse(1'b1, 1'b0, 33, 1'b0);
    expect_time("t5_set", 8'h12, 8'h34, 8'h00);
    set_mode = 1'b0;
    cyc(1);
    pulse(1'b1, 1'b1, 1, 1'b0);
    pulse(1'b1, 1'b0, 1, 1'b0);
    expect_time("t5_ignored", 8'h12, 8'h34, 8'h00);
    tick(1);
    expect_time("t5_resume", 8'h12, 8'h34, 8'h01);

    // 6: asynchronous reset mid-cycle with tick held high across release
    set_mode = 1'b1;
    pulse(1'b0, 1'b1, 3, 1'b0);
    pulse(1'b1, 1'b0, 46, 1'b0);
    set_mode = 1'b0;
    cyc(1);
    tick(30);
    expect_time("t6_pre", 8'h15, 8'h20, 8'h30);
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick_in = 1'b1;
    #1;
    expect_time("t6_async", 8'h07, 8'h00, 8'h00);
    chk("t6_async_pulse", {7'd0, sec_pulse}, 8'h00);
    chk("t6_async_wrap", {7'd0, day_wrap}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_time("t6_release", 8'h07, 8'h00, 8'h01);
    chk("t6_release_pulse", {7'd0, sec_pulse}, 8'h01);
    tick_in = 1'b0;
    cyc(2);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Consumes the slow square wave from the team's clock divider and maintains wall-clock time as BCD hours:minutes:seconds, 24-hour format.
- Fully synchronous to the system clock. The divider output is a data input, edge-detected internally, and never used as a clock.
- Supports a set mode in which hours and minutes are stepped by pre-debounced button pulses.
- Feeds the display multiplexer and the alarm comparator downstream.

Parameters:
- RST_HOUR, 8'h00, BCD hour loaded on reset; legal range 00-23.
- RST_MIN, 8'h00, BCD minute loaded on reset; legal range 00-59.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tick_in  in  1  divider square-wave output, registered in the clk domain. Each rising edge advances time by one second.
- set_mode  in  1  level; 1 = time-set mode, seconds frozen.
- inc_min  in  1  single-cycle pulse; step minutes (set mode only).
- inc_hour  in  1  single-cycle pulse; step hours (set mode only).
- hours  out  8  BCD hours {tens[7:4], units[3:0]}.
- minutes  out  8  BCD minutes.
- seconds  out  8  BCD seconds.
- sec_pulse  out  1  one-cycle strobe each time seconds advance.
- day_wrap  out  1  one-cycle strobe on the 23:59:59 -> 00:00:00 rollover.

Behaviour:
- Reset (async, any time, including mid-update):
  - hours = RST_HOUR, minutes = RST_MIN, seconds = 8'h00.
  - sec_pulse = 0, day_wrap = 0.
  - Edge register tick_q = 0. Consequently, if tick_in is high when reset is released, it counts as a rise on the first clk edge.
- Edge detect: rise = tick_in & ~tick_q. tick_q <= tick_in every clk.
- Run mode (set_mode = 0), on a clk edge with rise = 1:
  - Seconds increment mod 60.
  - A 59 -> 00 seconds carry increments minutes mod 60.
  - A 59 -> 00 minutes carry (together with the seconds carry) increments hours mod 24.
  - All fields update on that same clk edge; latency is one clk from the edge that samples tick_in = 1.
  - sec_pulse = 1 for exactly that cycle, aligned with the new time values.
  - day_wrap = 1 in the same cycle only when the prior value was 23:59:59.
- BCD rules:
  - Units wrap 9 -> 0 with a carry into tens.
  - Seconds and minutes wrap 59 -> 00.
  - Hours wrap 23 -> 00. This is checked on the full byte, so 19 -> 20 carries normally and 23 -> 00 wraps.
  - Nibble values A-F are never produced.
- Set mode (set_mode = 1):
  - Seconds forced to 00 on every clk edge while set_mode is high.
  - rise is ignored. sec_pulse and day_wrap stay 0.
  - inc_min: minutes +1 mod 60, with no carry into hours.
  - inc_hour: hours +1 mod 24, with no day_wrap.
  - inc_min and inc_hour in the same cycle: both applied independently.
- In run mode, inc_min and inc_hour are ignored.
- set_mode falling edge: counting resumes from hh:mm:00. The next tick rise produces :01.
- rise coinciding with set_mode = 1: set mode wins and the tick is lost by design.
- Pulses wider than one cycle on inc_min or inc_hour step once per cycle high; the upstream debouncer guarantees single-cycle pulses.
- Nothing other than reset restores RST_HOUR/RST_MIN.

Decomposition:
- Package time_pkg:
  - BCD limit constants SEC_MAX = 8'h59, MIN_MAX = 8'h59, HOUR_MAX = 8'h23.
  - A bcd_time struct typedef {hours, minutes, seconds}, shared with the alarm comparator and display mux.
- Sub-module bcd_mod_counter, instantiated three times:
  - Parameterised by a MAX BCD value.
  - Ports: clk, rst, reset value, inc, clr, value[7:0], carry (combinational: inc & value == MAX).
- The top level contains the edge detector, carry chaining and mode gating only.

Test Plan:
1. Release reset with tick_in = 0, then apply 3 tick rises -> seconds 00 -> 01 -> 02 -> 03, with one sec_pulse per rise, each one clk after the sampling edge.
2. Preload to 00:00:59 via set mode and 59 ticks, then one rise -> 00:01:00. A second scenario from 00:59:59, one rise -> 01:00:00. No day_wrap in either.
3. From 23:59:59, one rise -> 00:00:00, with day_wrap = 1 for exactly one cycle coincident with sec_pulse.
4. In set mode from 09:59:xx:
   - inc_min once -> 09:00:00 (no hour carry).
   - inc_hour 15 times -> 00:00:00 (wrap, no day_wrap).
   - Tick rises throughout leave seconds at 00.
   - Simultaneous inc_min and inc_hour -> 01:01:00.
5. Run mode: inc_min and inc_hour pulses -> no change. Drop set_mode at 12:34:00, then one rise -> 12:34:01.
6. Assert rst asynchronously between clk edges at 15:20:30 with RST_HOUR = 8'h07 -> outputs read 07:00:00 immediately, with strobes 0. If tick_in is held high across release, the first clk edge produces 07:00:01.
